// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system Avalon-MM PIO blocks: register offsets
// and the edge-type selector values.
package soc_system_pio_pkg;

    localparam logic [2:0] PIO_OFS_DATA = 3'd0;
    localparam logic [2:0] PIO_OFS_MASK = 3'd2;
    localparam logic [2:0] PIO_OFS_EDGE = 3'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous inputs.
// Every bit has its own chain of STAGES flops.
module soc_system_pio_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] chain_q [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/soc_system_edge_capture_pio.sv
// Avalon-MM input PIO: synchronised level readback, per-bit edge capture with
// write-1-to-clear, and a maskable level IRQ towards the HPS.
module soc_system_edge_capture_pio
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;
    localparam int CNT_W        = $clog2(PRIME_CYCLES + 1);

    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [CNT_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             primed;
    logic             wr_en;
    logic             unused_wdata;

    soc_system_pio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (in_port),
        .sync_o  (sync_q)
    );

    // Bus timing: a write commits on the edge where chipselect=1 and write_n=0;
    // readdata follows address with one cycle of latency, no read strobe.
    assign wr_en        = chipselect & ~write_n;
    assign primed       = (prime_cnt_q == CNT_W'(PRIME_CYCLES));
    assign unused_wdata = ^writedata;

    always_comb begin
        det = sync_q ^ prev_q;
        if (EDGE_TYPE == EDGE_RISE) det = sync_q & ~prev_q;
        else if (EDGE_TYPE == EDGE_FALL) det = ~sync_q & prev_q;
    end

    always_comb begin
        clr         = '0;
        irq_mask_d  = irq_mask_q;
        if (wr_en && address == PIO_OFS_EDGE) clr = writedata[WIDTH-1:0];
        if (wr_en && address == PIO_OFS_MASK) irq_mask_d = writedata[WIDTH-1:0];
        // OR-ing the new edge after the clear lets a simultaneous edge win.
        edge_cap_d  = (edge_cap_q & ~clr) | (det & {WIDTH{primed}});
        irq_d       = |(edge_cap_q & irq_mask_q);
        prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + CNT_W'(1);
        readdata_d  = '0;
        case (address)
            PIO_OFS_DATA: readdata_d[WIDTH-1:0] = sync_q;
            PIO_OFS_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            PIO_OFS_EDGE: readdata_d[WIDTH-1:0] = edge_cap_q;
            default:      readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q      <= '0;
            edge_cap_q  <= '0;
            irq_mask_q  <= '0;
            prime_cnt_q <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            prev_q      <= sync_q;
            edge_cap_q  <= edge_cap_d;
            irq_mask_q  <= irq_mask_d;
            prime_cnt_q <= prime_cnt_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
